// File: rtl/mult_drv_pkg.sv
// Shared types and default sizing for the multiplier block driver.
package mult_drv_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_FULL = 3'd2,
        REQ_READ  = 3'd3,
        COLLECT   = 3'd4,
        DONE      = 3'd5
    } drv_state_t;

    localparam int N_DEF     = 32;
    localparam int DEPTH_DEF = 64;
    localparam int IDX_W     = $clog2(DEPTH_DEF);
    localparam int SUM_W     = N_DEF + IDX_W;

endpackage

// File: rtl/mult_drv_watchdog.sv
// Idle watchdog: down-counter reloaded on clear, expires on the TIMEOUT-th enabled cycle.
module mult_drv_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= LOAD;
        end else if (i_clr) begin
            r_count <= LOAD;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/mult_block_driver.sv
// Host-side driver: issues one block of DEPTH multiplies, then reads the block back
// as an indexed result stream with a running block sum.
module mult_block_driver
    import mult_drv_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       op_valid,
    input  logic [15:0]                op_a,
    input  logic [15:0]                op_b,
    output logic                       op_ready,
    input  logic                       RDY_mult,
    output logic                       EN_mult,
    output logic [15:0]                mult_input0,
    output logic [15:0]                mult_input1,
    output logic                       EN_blockRead,
    input  logic                       VALID_memVal,
    input  logic [N-1:0]               memVal_data,
    output logic                       res_valid,
    output logic [N-1:0]               res_data,
    output logic [$clog2(DEPTH)-1:0]   res_index,
    output logic                       res_last,
    output logic [N+$clog2(DEPTH)-1:0] blk_sum,
    output logic                       blk_done,
    output logic                       err_timeout,
    output logic                       err_spurious
);

    // state     | meaning
    // IDLE      | waiting for run with the multiplier ready
    // ISSUE     | passing DEPTH operand pairs to the multiplier
    // WAIT_FULL | waiting for RDY_mult low (multiplier memory full)
    // REQ_READ  | EN_blockRead held until the first read-back word
    // COLLECT   | capturing the remaining read-back words
    // DONE      | block complete, blk_done pulses next cycle

    localparam int IW = $clog2(DEPTH);
    localparam int SW = N + IW;
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    drv_state_t    r_state;
    drv_state_t    w_state_next;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_words;
    logic          r_en_blockread;
    logic          r_res_valid;
    logic [N-1:0]  r_res_data;
    logic [IW-1:0] r_res_index;
    logic          r_res_last;
    logic [SW-1:0] r_blk_sum;
    logic          r_blk_done;
    logic          r_err_timeout;
    logic          r_err_spurious;

    logic w_capture;
    logic w_spurious;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_wd_expire;
    logic w_timeout;
    logic w_last_word;
    logic w_issue_last;
    logic w_start;

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (run && RDY_mult) w_state_next = ISSUE;
            ISSUE:     if (w_issue_last) w_state_next = WAIT_FULL;
            WAIT_FULL: begin
                if (w_timeout)      w_state_next = IDLE;
                else if (!RDY_mult) w_state_next = REQ_READ;
            end
            REQ_READ: begin
                if (w_last_word)    w_state_next = DONE;
                else if (w_capture) w_state_next = COLLECT;
                else if (w_timeout) w_state_next = IDLE;
            end
            COLLECT: begin
                if (w_last_word)    w_state_next = DONE;
                else if (w_timeout) w_state_next = IDLE;
            end
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        op_ready   = 1'b0;
        w_capture  = 1'b0;
        w_wd_en    = 1'b0;
        case (r_state)
            ISSUE:             op_ready = RDY_mult && (r_issued < DEPTH_C);
            WAIT_FULL:         w_wd_en = 1'b1;
            REQ_READ, COLLECT: begin
                w_wd_en   = 1'b1;
                w_capture = VALID_memVal;
            end
            default: ;
        endcase
        if (rst) begin
            op_ready = 1'b0;
        end
        w_spurious  = VALID_memVal && !((r_state == REQ_READ) || (r_state == COLLECT));
        EN_mult     = op_valid && op_ready;
        mult_input0 = rst ? 16'd0 : op_a;
        mult_input1 = rst ? 16'd0 : op_b;
    end

    assign w_issue_last = EN_mult && (r_issued == LAST_C);
    assign w_last_word  = w_capture && (r_words == LAST_C);
    // A word arriving on the expiry cycle still counts as progress.
    assign w_timeout    = w_wd_expire && !w_capture;
    assign w_wd_clr     = (w_state_next != r_state) || w_capture;
    assign w_start      = (r_state == IDLE) && (w_state_next == ISSUE);

    mult_drv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (CLK),
        .i_rst    (rst),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_issued       <= '0;
            r_words        <= '0;
            r_en_blockread <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_data     <= '0;
            r_res_index    <= '0;
            r_res_last     <= 1'b0;
            r_blk_sum      <= '0;
            r_blk_done     <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            r_res_valid    <= w_capture;
            r_res_last     <= w_last_word;
            r_blk_done     <= (r_state == DONE);
            r_en_blockread <= (w_state_next == REQ_READ);
            if (w_start) begin
                r_issued  <= '0;
                r_words   <= '0;
                r_blk_sum <= '0;
            end else begin
                if (EN_mult) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_capture) begin
                    r_res_data  <= memVal_data;
                    r_res_index <= r_words[IW-1:0];
                    r_words     <= r_words + 1'b1;
                    r_blk_sum   <= r_blk_sum + SW'(memVal_data);
                end
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign EN_blockRead = r_en_blockread;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_index    = r_res_index;
    assign res_last     = r_res_last;
    assign blk_sum      = r_blk_sum;
    assign blk_done     = r_blk_done;
    assign err_timeout  = r_err_timeout;
    assign err_spurious = r_err_spurious;

endmodule

// File: doc/mult_block_driver.md
# mult_block_driver

Host-side driver for the 64-entry multiplier block interface. Takes an operand stream and issues exactly one block of `DEPTH` multiplies into the multiplier. It then requests the block read-back and collects the returned products as an indexed result stream with a running block sum. It sits between the operand source and the multiplier, as the counterpart of the multiplier's `EN_mult`/`RDY_mult`/`EN_blockRead`/`VALID_memVal` interface.

## Interface
- `N`, 32, product/data width
- `DEPTH`, 64, products per block (power of two)
- `TIMEOUT`, 1024, max idle cycles while waiting on the multiplier
- `CLK` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `run` in 1: start a block (sampled in IDLE only)
- `op_valid` in 1: operand pair available
- `op_a`, `op_b` in 16 each: operands
- `op_ready` out 1: operand pair accepted this cycle when `op_valid` is also high
- `RDY_mult` in 1: multiplier ready for operands
- `EN_mult` out 1: issue multiply
- `mult_input0`, `mult_input1` out 16 each: operands to the multiplier
- `EN_blockRead` out 1: request block read-back
- `VALID_memVal` in 1: read-back word valid
- `memVal_data` in N: read-back word
- `res_valid` out 1: result word valid
- `res_data` out N: result word
- `res_index` out log2(DEPTH): word index
- `res_last` out 1: last word of the block
- `blk_sum` out N+log2(DEPTH): sum of all block words
- `blk_done` out 1: one-cycle pulse at block completion
- `err_timeout` out 1: sticky
- `err_spurious` out 1: sticky

## Operation
- States: IDLE, ISSUE, WAIT_FULL, REQ_READ, COLLECT, DONE.
- **IDLE**
  - `run && RDY_mult` moves to ISSUE.
  - Entering ISSUE clears the issue count, the word count and `blk_sum`.
- **ISSUE**
  - `op_ready = RDY_mult && issued < DEPTH`, combinational.
  - `EN_mult = op_valid && op_ready`.
  - `mult_input0/1 = op_a/op_b`, combinational pass-through; the multiplier registers them.
  - Each `EN_mult` increments the issue count.
  - After `DEPTH` issues, move to WAIT_FULL.
  - Gaps in `op_valid` are allowed.
  - `run` is ignored after leaving IDLE.
- **WAIT_FULL:** wait for `RDY_mult == 0` (multiplier memory full), then move to REQ_READ.
- **REQ_READ**
  - `EN_blockRead = 1`, held until the first `VALID_memVal`.
  - That word is captured as index 0; move to COLLECT.
- **COLLECT**
  - Each `VALID_memVal` captures `memVal_data` and increments the word count.
  - On the `DEPTH`-th word, move to DONE.
- **DONE:** `blk_done = 1` for one cycle, then IDLE.
- **Arithmetic:** `blk_sum` accumulates zero-extended words. It is N+6 = 38 bits at defaults, with no overflow possible. It holds its value until the next ISSUE entry.
- **Watchdog**
  - Counts cycles in WAIT_FULL, REQ_READ and COLLECT.
  - Cleared on every state change and on every captured word.
  - Reaching `TIMEOUT` sets `err_timeout` and returns to IDLE with no `blk_done`.
- **Spurious data:** `VALID_memVal` in IDLE, ISSUE, WAIT_FULL or DONE sets `err_spurious`. The word is dropped and produces no `res_valid`.
- **Reset:** `rst` at any time returns to IDLE with all counters, outputs and error flags at 0. The multiplier is reset from the same source, with `rst_n = ~rst`.

## Timing
- All outputs are 0 during and after reset.
- `op_ready`, `EN_mult` and `mult_input0/1` are combinational. `EN_blockRead` and all other outputs are registered.
- **Result stream**
  - `res_valid`, `res_data` and `res_index` follow `VALID_memVal` by exactly 1 cycle.
  - `res_last` coincides with index `DEPTH-1`.
  - There is no backpressure; a word is presented for one cycle only.
- `blk_sum` includes the last word in the same cycle that `res_last` is high.
- `blk_done` is asserted one cycle after `res_last`.
- `EN_blockRead` asserts on the first cycle of REQ_READ, one cycle after `RDY_mult` is sampled low.
- Minimum block time: `DEPTH` issue cycles, then multiplier pipeline and fill latency, then `DEPTH` collect cycles, plus 2.

## Structure
- Package `mult_drv_pkg` contains:
  - the `drv_state_t` enum;
  - `DEPTH_DEF = 64`;
  - `IDX_W = $clog2(DEPTH)`;
  - `SUM_W = N + IDX_W`.
- One sub-module, `mult_drv_watchdog`: a counter with clear/enable/expire, parameterised by `TIMEOUT`.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `op_valid = 1` → all outputs 0, `op_ready = 0`, state IDLE.
- **Full block:** `op_a = i+1`, `op_b = 3` for i = 0..63, back-to-back, with the multiplier model attached → exactly 64 `EN_mult` pulses and one `EN_blockRead` assertion. `res_data` = 3, 6, …, 192 at indices 0..63, `res_last` at 63, `blk_sum = 6240`, `blk_done` one cycle after `res_last`.
- **Operand gaps:** toggle `op_valid` every other cycle → still exactly 64 `EN_mult` pulses; `op_ready` is 0 from the 65th offer on.
- **Max values:** all operands `0xFFFF` → every `res_data = 0xFFFE0001`, `blk_sum = 0x3F_FF80_0040`, no errors.
- **Timeout:** `TIMEOUT = 16`, model holds `RDY_mult = 1` after 64 issues → `err_timeout = 1` after 16 cycles in WAIT_FULL, state IDLE, no `blk_done`. Injecting `VALID_memVal` during ISSUE → `err_spurious = 1`, no `res_valid`, block completes normally.
- **Reset mid-operation:** reset after 10 collected words → next cycle all outputs 0. A fresh `run` completes a correct block.
